// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage RV32I pipeline: shadow EX/MEM/WB scoreboard
// driving stall, flush, bubble and operand-forwarding controls.
module hazard_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses1;
    logic       uses2;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // x0 is folded into the flags here, so a match on x0 can never occur downstream.
  function automatic slot_t decode_slot(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic vld);
    slot_t s;
    logic  u1, u2, w, ld;
    u1 = 1'b0;
    u2 = 1'b0;
    w  = 1'b0;
    ld = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: w = 1'b1;
      OP_JALR, OP_IMM:          begin u1 = 1'b1; w = 1'b1; end
      OP_LOAD:                  begin u1 = 1'b1; w = 1'b1; ld = 1'b1; end
      OP_BRANCH, OP_STORE:      begin u1 = 1'b1; u2 = 1'b1; end
      OP_OP:                    begin u1 = 1'b1; u2 = 1'b1; w = 1'b1; end
      default:                  begin u1 = 1'b0; u2 = 1'b0; w = 1'b0; ld = 1'b0; end
    endcase
    s.valid = vld;
    s.wr    = w & (rd != 5'd0);
    s.load  = ld;
    s.rd    = rd;
    s.rs1   = rs1;
    s.rs2   = rs2;
    s.uses1 = u1 & (rs1 != 5'd0);
    s.uses2 = u2 & (rs2 != 5'd0);
    return s;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_ok, input logic [4:0] m_rd,
                                         input logic w_ok, input logic [4:0] w_rd,
                                         input logic [4:0] rs, input logic uses);
    logic [1:0] sel;
    if (uses && (rs != 5'd0) && m_ok && (m_rd == rs)) begin
      sel = 2'b01;
    end else if (uses && (rs != 5'd0) && w_ok && (w_rd == rs)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  slot_t            id_dec_s;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             load_use_s;
  logic             pc_en_s, ifid_en_s, ifid_flush_s, idex_bubble_s;
  logic             unused_s;

  assign unused_s = ^{id_instr[31:25], id_instr[14:12], mem_q.rs1, mem_q.rs2, mem_q.uses1,
                      mem_q.uses2, wb_q.load, wb_q.rs1, wb_q.rs2, wb_q.uses1, wb_q.uses2};

  // Decode ID and detect a load in EX feeding an ID source.
  always_comb begin
    id_dec_s   = decode_slot(id_instr[6:0], id_instr[11:7], id_instr[19:15],
                             id_instr[24:20], id_valid);
    load_use_s = ex_q.valid & ex_q.load & ex_q.wr & id_dec_s.valid &
                 ((id_dec_s.uses1 & (id_dec_s.rs1 == ex_q.rd)) |
                  (id_dec_s.uses2 & (id_dec_s.rs2 == ex_q.rd)));
  end

  // Prioritised sequencing: freeze, redirect flush, load-use stall, normal advance.
  always_comb begin
    pc_en_s       = 1'b1;
    ifid_en_s     = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_d       = stall_q;
    flush_d       = flush_q;
    if (mem_busy) begin
      pc_en_s   = 1'b0;
      ifid_en_s = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      ex_d          = SLOT_EMPTY;
      mem_d         = ex_q;
      wb_d          = mem_q;
      flush_d       = sat_inc(flush_q);
    end else if (load_use_s) begin
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_bubble_s = 1'b1;
      ex_d          = SLOT_EMPTY;
      mem_d         = ex_q;
      wb_d          = mem_q;
      stall_d       = sat_inc(stall_q);
    end else begin
      ex_d  = id_dec_s;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  // Scoreboard slots and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= SLOT_EMPTY;
      mem_q   <= SLOT_EMPTY;
      wb_q    <= SLOT_EMPTY;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Reset forces the run-state controls without waiting for a clock.
  assign pc_en       = rst_n ? pc_en_s       : 1'b1;
  assign ifid_en     = rst_n ? ifid_en_s     : 1'b1;
  assign ifid_flush  = rst_n ? ifid_flush_s  : 1'b0;
  assign idex_bubble = rst_n ? idex_bubble_s : 1'b0;

  assign fwd_a = fwd_sel(mem_q.valid & mem_q.wr & ~mem_q.load, mem_q.rd,
                         wb_q.valid & wb_q.wr, wb_q.rd, ex_q.rs1, ex_q.uses1);
  assign fwd_b = fwd_sel(mem_q.valid & mem_q.wr & ~mem_q.load, mem_q.rd,
                         wb_q.valid & wb_q.wr, wb_q.rd, ex_q.rs2, ex_q.uses2);

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed vector table, saturation and
// asynchronous-reset sequences, then random traffic against an in-flight instruction model.
module tb_hazard_sched;
  localparam int CW = 4;
  localparam int CMAX = 15;

  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] ADD6  = 32'h00228333;
  localparam logic [31:0] ADDI3 = 32'h00100193;
  localparam logic [31:0] ADD4  = 32'h00318233;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADD60 = 32'h00000333;
  localparam logic [31:0] LUI5  = 32'h000012B7;

  logic          clk, rst_n;
  logic [31:0]   id_instr;
  logic          id_valid, ex_redirect, mem_busy;
  logic          pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk, n_err;

  hazard_sched #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw instruction words in flight (0 = EX, 1 = MEM, 2 = WB).
  logic [31:0] pw [3];
  bit          pv [3];
  int          m_stall, m_flush;

  function automatic int dst(input logic [31:0] w);
    case (w[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011: return int'(w[11:7]);
      default: return 0;
    endcase
  endfunction

  function automatic int src1(input logic [31:0] w);
    case (w[6:0])
      7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
      7'b0010011, 7'b0110011: return int'(w[19:15]);
      default: return 0;
    endcase
  endfunction

  function automatic int src2(input logic [31:0] w);
    case (w[6:0])
      7'b1100011, 7'b0100011, 7'b0110011: return int'(w[24:20]);
      default: return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic [31:0] w);
    return w[6:0] == 7'b0000011;
  endfunction

  function automatic int fwd_of(input int s);
    if (s == 0) return 0;
    if (pv[1] && !is_ld(pw[1]) && dst(pw[1]) == s) return 1;
    if (pv[2] && dst(pw[2]) == s) return 2;
    return 0;
  endfunction

  function automatic bit hazard(input logic [31:0] w, input bit v);
    int d;
    d = dst(pw[0]);
    return pv[0] && is_ld(pw[0]) && d != 0 && v &&
           ((src1(w) != 0 && src1(w) == d) || (src2(w) != 0 && src2(w) == d));
  endfunction

  function automatic int sat(input int x);
    return (x + 1 > CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin pw[i] = 32'h0; pv[i] = 1'b0; end
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_adv(input logic [31:0] w, input bit v, input bit r, input bit b);
    bit lu;
    lu = hazard(w, v);
    if (!b) begin
      pw[2] = pw[1]; pv[2] = pv[1];
      pw[1] = pw[0]; pv[1] = pv[0];
      if (r || lu) begin
        pw[0] = 32'h0; pv[0] = 1'b0;
        if (r) m_flush = sat(m_flush);
        else   m_stall = sat(m_stall);
      end else begin
        pw[0] = w; pv[0] = v;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic r, input logic b);
    id_instr = w; id_valid = v; ex_redirect = r; mem_busy = b;
  endtask

  // One model-checked cycle: drive, compare before the edge, advance model at the edge.
  task automatic step(input logic [31:0] w, input logic v, input logic r, input logic b);
    bit lu;
    int ep, eb;
    drive(w, v, r, b);
    #2;
    lu = hazard(w, v);
    ep = (b || (!r && lu)) ? 0 : 1;
    eb = (!b && (r || lu)) ? 1 : 0;
    chk("pc_en", {31'd0, pc_en}, ep);
    chk("ifid_en", {31'd0, ifid_en}, ep);
    chk("ifid_flush", {31'd0, ifid_flush}, (!b && r) ? 1 : 0);
    chk("idex_bubble", {31'd0, idex_bubble}, eb);
    chk("fwd_a", {30'd0, fwd_a}, fwd_of(src1(pw[0])));
    chk("fwd_b", {30'd0, fwd_b}, fwd_of(src2(pw[0])));
    chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
    chk("flush_cnt", {28'd0, flush_cnt}, m_flush);
    @(posedge clk);
    model_adv(w, v, r, b);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pc_en"}, {31'd0, pc_en}, 1);
    chk({tag, "_ifid_en"}, {31'd0, ifid_en}, 1);
    chk({tag, "_ifid_flush"}, {31'd0, ifid_flush}, 0);
    chk({tag, "_idex_bubble"}, {31'd0, idex_bubble}, 0);
    chk({tag, "_fwd"}, {28'd0, fwd_a, fwd_b}, 0);
    chk({tag, "_cnt"}, {24'd0, stall_cnt, flush_cnt}, 0);
  endtask

  typedef struct {
    logic [31:0] w;
    logic        v, r, b;
    logic        pc, ifen, fl, bub;
    logic [1:0]  fa, fb;
    int          sc, fc;
  } vec_t;

  vec_t vt [25];

  initial begin
    n_chk = 0;
    n_err = 0;
    vt[0]  = '{LW5,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0};
    vt[1]  = '{ADD6,  1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0};
    vt[2]  = '{ADD6,  1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[3]  = '{NOP,   1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b00, 1, 0};
    vt[4]  = '{ADDI3, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[5]  = '{ADD4,  1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[6]  = '{ADDI3, 1, 0, 0, 1, 1, 0, 0, 2'b01, 2'b01, 1, 0};
    vt[7]  = '{NOP,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[8]  = '{ADD4,  1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[9]  = '{NOP,   1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b10, 1, 0};
    vt[10] = '{LW0,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[11] = '{ADD60, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[12] = '{LW5,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[13] = '{LUI5,  1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[14] = '{NOP,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[15] = '{LW5,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0};
    vt[16] = '{ADD6,  1, 1, 0, 1, 1, 1, 1, 2'b00, 2'b00, 1, 0};
    vt[17] = '{NOP,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1};
    vt[18] = '{LW5,   1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1};
    vt[19] = '{ADD6,  1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1};
    vt[20] = '{ADD6,  1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1};
    vt[21] = '{ADD6,  1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1};
    vt[22] = '{ADD6,  1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1};
    vt[23] = '{ADD6,  1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2, 1};
    vt[24] = '{NOP,   1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2, 1};

    rst_n = 1'b0;
    drive(NOP, 1'b0, 1'b0, 1'b0);
    model_clear();
    #3;
    reset_checks("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].w, vt[i].v, vt[i].r, vt[i].b);
      #2;
      chk($sformatf("v%0d_ctl", i), {28'd0, pc_en, ifid_en, ifid_flush, idex_bubble},
          {28'd0, vt[i].pc, vt[i].ifen, vt[i].fl, vt[i].bub});
      chk($sformatf("v%0d_fwd", i), {28'd0, fwd_a, fwd_b}, {28'd0, vt[i].fa, vt[i].fb});
      chk($sformatf("v%0d_stall", i), {28'd0, stall_cnt}, vt[i].sc);
      chk($sformatf("v%0d_flush", i), {28'd0, flush_cnt}, vt[i].fc);
      @(posedge clk);
      model_adv(vt[i].w, vt[i].v, vt[i].r, vt[i].b);
      #1;
    end

    for (int i = 0; i < 20; i++) begin
      step(LW5, 1'b1, 1'b0, 1'b0);
      step(ADD6, 1'b1, 1'b0, 1'b0);
      step(ADD6, 1'b1, 1'b0, 1'b0);
    end
    chk("stall_saturated", {28'd0, stall_cnt}, CMAX);

    step(LW5, 1'b1, 1'b0, 1'b0);
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    #2;
    chk("pre_reset_bubble", {31'd0, idex_bubble}, 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    reset_checks("mid_stall");
    drive(ADD6, 1'b1, 1'b1, 1'b1);
    #1;
    reset_checks("rst_vs_inputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("post_reset_no_stall", {31'd0, idex_bubble}, 0);
    @(posedge clk);
    model_adv(ADD6, 1'b1, 1'b0, 1'b0);
    #1;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r, w;
      logic [6:0]  op;
      case ($urandom_range(0, 9))
        0: op = 7'b0110111;
        1: op = 7'b0010111;
        2: op = 7'b1101111;
        3: op = 7'b1100111;
        4: op = 7'b1100011;
        5: op = 7'b0000011;
        6: op = 7'b0100011;
        7: op = 7'b0010011;
        8: op = 7'b0110011;
        default: op = 7'b1111111;
      endcase
      r = $urandom();
      w = {r[31:25], 3'd0, r[21:20], 3'd0, r[16:15], r[14:12], 3'd0, r[8:7], op};
      step(w, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Keeps its own shadow scoreboard of EX, MEM and WB occupancy, decoded from the instruction in ID as it advances.
- From the scoreboard it drives PC/IF-ID enables, IF/ID flush, ID/EX bubble insertion and EX operand forwarding selects.
- Sits beside the decode stage and the immediate generator. It is the single sequencing authority for stalls and flushes.

Parameters:
CNT_W, 16, width of the saturating stall and flush performance counters (min 4).

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
id_instr  in  32  instruction currently held in the IF/ID register.
id_valid  in  1  id_instr is a real instruction (0 = empty/bubble).
ex_redirect  in  1  branch taken or JAL/JALR resolved in EX this cycle.
mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
pc_en  out  1  PC register load enable.
ifid_en  out  1  IF/ID register load enable.
ifid_flush  out  1  clear IF/ID to a bubble at the next edge.
idex_bubble  out  1  load a bubble (NOP, valid=0) into ID/EX at the next edge.
fwd_a  out  2  EX operand A source: 00 = regfile, 01 = MEM result, 10 = WB result.
fwd_b  out  2  EX operand B source, same encoding.
stall_cnt  out  CNT_W  count of load-use stall cycles, saturating.
flush_cnt  out  CNT_W  count of redirect flush cycles, saturating.

Behaviour:
- Decode of id_instr (opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20]):
  - uses rs1: JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - uses rs2: BRANCH, STORE, OP.
  - writes rd: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR, LOAD, OP-IMM, OP.
  - is_load: LOAD.
  - Unknown opcodes: use nothing, write nothing.
  - A source or destination equal to x0 never matches.
- Slots EX, MEM, WB each hold {valid, wr, load, rd, rs1, rs2, uses1, uses2}. A slot with valid=0 never matches.
- Priority per cycle, highest first: mem_busy, ex_redirect, load-use, normal.
- mem_busy=1 (freeze):
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0.
  - All slots hold; counters hold; ex_redirect is ignored (its source holds it until mem_busy drops).
- ex_redirect=1 (flush):
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1.
  - At the edge: EX slot <= empty, MEM <= old EX, WB <= old MEM.
  - flush_cnt += 1.
- Load-use, when ex.valid & ex.load & ex.wr & id_valid, and (uses1 & rs1 == ex.rd) or (uses2 & rs2 == ex.rd):
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  - EX <= empty, MEM/WB advance, stall_cnt += 1.
  - Lasts exactly 1 cycle: the load has moved to MEM by the next cycle and the condition clears.
- Normal:
  - pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
  - EX <= decode(id_instr) with valid=id_valid; MEM <= EX; WB <= MEM.
- Forwarding is combinational from the registered slots and is valid even during a freeze. For operand A:
  - fwd_a=01 if mem.valid & mem.wr & !mem.load & mem.rd==ex.rs1 & ex.uses1 & ex.rs1!=0.
  - else fwd_a=10 if wb.valid & wb.wr & wb.rd==ex.rs1 & ex.uses1 & ex.rs1!=0.
  - else 00.
  - fwd_b is identical using rs2/uses2. MEM has priority over WB, so the youngest producer wins.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 (no wrap).
  - Not incremented during freeze.
- Reset (async, rst_n low, any time including mid-stall or mid-flush):
  - All slots invalid, both counters 0.
  - Outputs immediately: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00.
  - No pending stall survives reset.
- All control outputs are combinational from the current inputs plus slot state. There is no added latency.

Test Plan:
- Load-use: LW x5,0(x1) then ADD x6,x5,x2 → exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt 0→1. When ADD reaches EX, fwd_a=10.
- Back-to-back ALU: ADDI x3,x0,1 then ADD x4,x3,x3 → no stall; with ADD in EX, fwd_a=01 and fwd_b=01. An independent instruction between them instead gives 10/10.
- x0 and non-users: LW x0,0(x1) then ADD x6,x0,x0 → no stall, fwd 00. LW x5 then LUI x5,1 → no stall (LUI uses no rs).
- Redirect versus load-use: ex_redirect=1 while a load-use condition is also true → ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt +1, stall_cnt unchanged.
- Freeze: mem_busy=1 for 3 cycles during the LW/ADD hazard → pc_en=0, idex_bubble=0, counters unchanged, fwd stable. After release, the 1-cycle stall occurs.
- Saturation/reset: with CNT_W=4, 20 load-use stalls → stall_cnt=15. Asserting rst_n=0 mid-stall → counters 0, pc_en=1, idex_bubble=0 immediately, with no clock required.
